// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter onto the HPS SDRAM Avalon-MM bridge.
// An in-order tag FIFO of outstanding reads steers returned data to the requester that issued it.
//
// state  | meaning
// IDLE   | arbitrate among eligible requesters; winner forwarded combinationally
// LOCKED | slave stalled the winner; keep forwarding sel_q until accepted
module sdram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_PEND = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [ADDR_W-1:0]             m0_address,
  input  logic                          m0_read,
  input  logic                          m0_write,
  input  logic [DATA_W-1:0]             m0_writedata,
  input  logic [DATA_W/8-1:0]           m0_byteenable,
  output logic                          m0_waitrequest,
  output logic [DATA_W-1:0]             m0_readdata,
  output logic                          m0_readdatavalid,
  input  logic [ADDR_W-1:0]             m1_address,
  input  logic                          m1_read,
  input  logic                          m1_write,
  input  logic [DATA_W-1:0]             m1_writedata,
  input  logic [DATA_W/8-1:0]           m1_byteenable,
  output logic                          m1_waitrequest,
  output logic [DATA_W-1:0]             m1_readdata,
  output logic                          m1_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  output logic                          s_write,
  output logic [DATA_W-1:0]             s_writedata,
  output logic [DATA_W/8-1:0]           s_byteenable,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_count,
  output logic                          err_unexp_rdv,
  output logic                          err_rw_both
);

  localparam int PTR_W  = $clog2(MAX_PEND);
  localparam int PEND_W = $clog2(MAX_PEND+1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q;
  logic                sel_q;
  logic                last_grant_q;
  logic                run_q;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [MAX_PEND-1:0] tags_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic                err_unexp_q, err_rw_q;

  logic room, elig0, elig1, sel_c, active;
  logic cmd_rd, cmd_wr, accept, push, pop, head_tag;

  // run_q keeps the command path quiet from reset assertion until the first edge after release
  assign room  = pend_q < PEND_W'(MAX_PEND);
  assign elig0 = run_q & (m0_read | m0_write) & (m0_write | room);
  assign elig1 = run_q & (m1_read | m1_write) & (m1_write | room);

  always_comb begin
    sel_c  = 1'b0;
    active = 1'b0;
    if (state_q == LOCKED) begin
      sel_c  = sel_q;
      active = sel_q ? elig1 : elig0;
    end else begin
      active = elig0 | elig1;
      sel_c  = (elig0 & elig1) ? ~last_grant_q : elig1;
    end
  end

  // read+write together is treated as a write
  assign cmd_wr = sel_c ? m1_write : m0_write;
  assign cmd_rd = (sel_c ? m1_read : m0_read) & ~cmd_wr;

  assign s_read       = active & cmd_rd;
  assign s_write      = active & cmd_wr;
  assign s_address    = sel_c ? m1_address    : m0_address;
  assign s_writedata  = sel_c ? m1_writedata  : m0_writedata;
  assign s_byteenable = sel_c ? m1_byteenable : m0_byteenable;

  assign m0_waitrequest = ~(active & ~sel_c) | s_waitrequest;
  assign m1_waitrequest = ~(active &  sel_c) | s_waitrequest;

  assign accept   = active & ~s_waitrequest;
  assign push     = accept & cmd_rd;
  assign pop      = s_readdatavalid & (pend_q != '0);
  assign head_tag = tags_q[rd_ptr_q];

  assign m0_readdatavalid = pop & ~head_tag;
  assign m1_readdatavalid = pop &  head_tag;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  assign pend_d        = pend_q + PEND_W'(push) - PEND_W'(pop);
  assign pend_count    = pend_q;
  assign err_unexp_rdv = err_unexp_q;
  assign err_rw_both   = err_rw_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      run_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) last_grant_q <= sel_c;
      case (state_q)
        IDLE: begin
          if (active && s_waitrequest) begin
            state_q <= LOCKED;
            sel_q   <= sel_c;
          end
        end
        LOCKED: begin
          if (!active || !s_waitrequest) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tags_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= '0;
      err_unexp_q <= 1'b0;
      err_rw_q    <= 1'b0;
    end else begin
      if (push) begin
        tags_q[wr_ptr_q] <= sel_c;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      pend_q <= pend_d;
      if (s_readdatavalid && pend_q == '0) err_unexp_q <= 1'b1;
      if ((m0_read && m0_write) || (m1_read && m1_write)) err_rw_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of the arbitration and read-return rules.
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int MAX_PEND = 8;
  localparam int BE_W     = DATA_W/8;
  localparam int PEND_W   = $clog2(MAX_PEND+1);

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [PEND_W-1:0] pend_count;
  logic              err_unexp_rdv, err_rw_both;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int q[$];
  int last_m;
  int lock_m;
  bit m_err_unexp, m_err_rw;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_unexp_rdv(err_unexp_rdv), .err_rw_both(err_rw_both)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '1;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '1;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_reset_n = 0;
    repeat (2) tick();
    reset_reset_n = 1;
    tick();
    q.delete(); last_m = 1; lock_m = -1; m_err_unexp = 0; m_err_rw = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_reset_n = 0;
    m0_read = 1; m1_write = 1; m0_address = 32'h40; m1_address = 32'h80;
    tick(); settle();
    tests_run++;
    if ({s_read, s_write} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_cmd: got %b required 00", {s_read, s_write});
    end
    tests_run++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      tests_failed++; $display("FAIL reset_waitreq: got %b required 11", {m0_waitrequest, m1_waitrequest});
    end
    tests_run++;
    if ({m0_readdatavalid, m1_readdatavalid, err_unexp_rdv, err_rw_both} !== 4'b0000 || pend_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: rdv/err got %b pend %0d required 0000 pend 0",
               {m0_readdatavalid, m1_readdatavalid, err_unexp_rdv, err_rw_both}, pend_count);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    m0_write = 1; m0_address = 32'h100; s_waitrequest = 0;
    settle();
    tests_run++;
    if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h100 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write: wr=%b rd=%b addr=%h w0=%b w1=%b required 1 0 100 0 1",
               s_write, s_read, s_address, m0_waitrequest, m1_waitrequest);
    end
    tick();
    // last grant is now 0, so a tie must go to m1
    m1_write = 1; m1_address = 32'h180;
    settle();
    tests_run++;
    if (s_address !== 32'h180 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL tie_after_m0: addr=%h w0=%b w1=%b required 180 1 0", s_address, m0_waitrequest, m1_waitrequest);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention();
    int cnt0 = 0;
    int cnt1 = 0;
    int g;
    m0_write = 1; m1_write = 1; m0_address = 32'hA000; m1_address = 32'hB000;
    for (int i = 0; i < 8; i++) begin
      settle();
      g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
      if (g == 0) cnt0++;
      if (g == 1) cnt1++;
      tests_run++;
      if (g !== (i % 2) || s_address !== ((i % 2) ? 32'hB000 : 32'hA000)) begin
        tests_failed++; $display("FAIL contention_grant[%0d]: got %0d addr %h required %0d", i, g, s_address, i % 2);
      end
      tick();
    end
    tests_run++;
    if (cnt0 !== 4 || cnt1 !== 4) begin
      tests_failed++; $display("FAIL contention_share: got %0d/%0d required 4/4", cnt0, cnt1);
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    m0_write = 1; m0_address = 32'h200;
    tick();
    m1_write = 1; m1_address = 32'h300; s_waitrequest = 1;
    for (int c = 1; c <= 5; c++) begin
      settle();
      tests_run++;
      if (s_address !== 32'h300 || s_write !== 1'b1 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
        tests_failed++;
        $display("FAIL lock_hold[%0d]: addr=%h wr=%b w0=%b w1=%b required 300 1 1 1",
                 c, s_address, s_write, m0_waitrequest, m1_waitrequest);
      end
      tick();
    end
    s_waitrequest = 0;
    settle();
    tests_run++;
    if (s_address !== 32'h300 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
      tests_failed++; $display("FAIL lock_accept: addr=%h w0=%b w1=%b required 300 1 0", s_address, m0_waitrequest, m1_waitrequest);
    end
    tick();
    m1_write = 0;
    settle();
    tests_run++;
    if (s_address !== 32'h200 || m0_waitrequest !== 1'b0 || s_write !== 1'b1) begin
      tests_failed++; $display("FAIL lock_then_m0: addr=%h w0=%b wr=%b required 200 0 1", s_address, m0_waitrequest, s_write);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_read_routing();
    logic [DATA_W-1:0] d [3];
    d[0] = 64'hD1D1_0000_1111_0001; d[1] = 64'hD2D2_0000_2222_0002; d[2] = 64'hD3D3_0000_3333_0003;
    m0_read = 1; m0_address = 32'hA; tick();
    m0_read = 0; m1_read = 1; m1_address = 32'hB; tick();
    m1_read = 0; m0_read = 1; m0_address = 32'hC;
    settle();
    tests_run++;
    if (s_read !== 1'b1 || s_address !== 32'hC || pend_count !== 4'd2) begin
      tests_failed++; $display("FAIL route_issue: rd=%b addr=%h pend=%0d required 1 c 2", s_read, s_address, pend_count);
    end
    tick();
    m0_read = 0;
    for (int k = 0; k < 3; k++) begin
      s_readdatavalid = 1; s_readdata = d[k];
      settle();
      tests_run++;
      if (pend_count !== PEND_W'(3 - k) || m0_readdatavalid !== (k != 1) || m1_readdatavalid !== (k == 1) ||
          m0_readdata !== d[k] || m1_readdata !== d[k]) begin
        tests_failed++;
        $display("FAIL route_return[%0d]: pend=%0d v0=%b v1=%b data=%h required pend %0d v0 %b v1 %b data %h",
                 k, pend_count, m0_readdatavalid, m1_readdatavalid, m0_readdata, 3 - k, k != 1, k == 1, d[k]);
      end
      tick();
    end
    s_readdatavalid = 0;
    settle();
    tests_run++;
    if (pend_count !== '0) begin
      tests_failed++; $display("FAIL route_drained: pend=%0d required 0", pend_count);
    end
    clear_inputs();
  endtask

  task automatic test_full_stall();
    m0_read = 1; m0_address = 32'h5000;
    repeat (MAX_PEND) tick();
    m1_write = 1; m1_address = 32'h6000;
    settle();
    tests_run++;
    if (pend_count !== PEND_W'(MAX_PEND) || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0 ||
        s_write !== 1'b1 || s_address !== 32'h6000) begin
      tests_failed++;
      $display("FAIL full_stall: pend=%0d w0=%b w1=%b wr=%b addr=%h required 8 1 0 1 6000",
               pend_count, m0_waitrequest, m1_waitrequest, s_write, s_address);
    end
    tick();
    m1_write = 0; s_readdatavalid = 1;
    settle();
    tests_run++;
    if (m0_waitrequest !== 1'b1 || s_read !== 1'b0 || m0_readdatavalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pop_same_cycle: w0=%b rd=%b v0=%b required 1 0 1", m0_waitrequest, s_read, m0_readdatavalid);
    end
    tick();
    s_readdatavalid = 0;
    settle();
    tests_run++;
    if (m0_waitrequest !== 1'b0 || s_read !== 1'b1 || pend_count !== PEND_W'(MAX_PEND - 1)) begin
      tests_failed++;
      $display("FAIL full_unstall: w0=%b rd=%b pend=%0d required 0 1 7", m0_waitrequest, s_read, pend_count);
    end
    tick();
    m0_read = 0; s_readdatavalid = 1;
    repeat (MAX_PEND) tick();
    s_readdatavalid = 0;
    settle();
    tests_run++;
    if (pend_count !== '0 || err_unexp_rdv !== 1'b0) begin
      tests_failed++; $display("FAIL full_drain: pend=%0d err=%b required 0 0", pend_count, err_unexp_rdv);
    end
    clear_inputs();
  endtask

  function automatic int pick(input bit rd0, input bit wr0, input bit rd1, input bit wr1);
    bit e0, e1;
    e0 = (rd0 | wr0) && (wr0 || q.size() < MAX_PEND);
    e1 = (rd1 | wr1) && (wr1 || q.size() < MAX_PEND);
    if (lock_m >= 0) return ((lock_m == 0) ? e0 : e1) ? lock_m : -1;
    if (e0 && e1) return 1 - last_m;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic test_random();
    bit rd [2], wr [2], hold [2], acc [2];
    logic [ADDR_W-1:0] addr [2];
    int sel, ptag, r;
    bit exp_rd, exp_wr, sw, rdv, pop;
    apply_reset();
    hold[0] = 0; hold[1] = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          r = $urandom_range(0, 39);
          rd[i] = (r >= 12 && r <= 23) || r == 39;
          wr[i] = (r >= 24 && r <= 35) || r == 39;
          addr[i] = $urandom;
        end
        acc[i] = 0;
      end
      m0_read = rd[0]; m0_write = wr[0]; m0_address = addr[0]; m0_writedata = {$urandom, $urandom};
      m1_read = rd[1]; m1_write = wr[1]; m1_address = addr[1]; m1_writedata = {$urandom, $urandom};
      sw = ($urandom_range(0, 2) == 0);
      rdv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_waitrequest = sw; s_readdatavalid = rdv; s_readdata = {$urandom, $urandom};
      settle();
      sel = pick(rd[0], wr[0], rd[1], wr[1]);
      exp_wr = (sel >= 0) && wr[sel];
      exp_rd = (sel >= 0) && rd[sel] && !wr[sel];
      pop = rdv && q.size() > 0;
      ptag = pop ? q[0] : -1;
      tests_run++;
      if (s_read !== exp_rd || s_write !== exp_wr) begin
        tests_failed++; $display("FAIL rand_cmd[%0d]: got rd %b wr %b required rd %b wr %b", cyc, s_read, s_write, exp_rd, exp_wr);
      end
      if (sel >= 0) begin
        tests_run++;
        if (s_address !== addr[sel]) begin
          tests_failed++; $display("FAIL rand_addr[%0d]: got %h required %h", cyc, s_address, addr[sel]);
        end
      end
      tests_run++;
      if (m0_waitrequest !== !(sel == 0 && !sw) || m1_waitrequest !== !(sel == 1 && !sw)) begin
        tests_failed++;
        $display("FAIL rand_waitreq[%0d]: got %b%b required %b%b", cyc, m0_waitrequest, m1_waitrequest,
                 !(sel == 0 && !sw), !(sel == 1 && !sw));
      end
      tests_run++;
      if (m0_readdatavalid !== (ptag == 0) || m1_readdatavalid !== (ptag == 1) || m1_readdata !== s_readdata) begin
        tests_failed++;
        $display("FAIL rand_rdv[%0d]: got %b%b required %b%b", cyc, m0_readdatavalid, m1_readdatavalid, ptag == 0, ptag == 1);
      end
      tests_run++;
      if (pend_count !== PEND_W'(q.size()) || err_unexp_rdv !== m_err_unexp || err_rw_both !== m_err_rw) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: pend %0d err %b%b required pend %0d err %b%b", cyc, pend_count,
                 err_unexp_rdv, err_rw_both, q.size(), m_err_unexp, m_err_rw);
      end
      tick();
      if (rdv && q.size() == 0) m_err_unexp = 1;
      if ((rd[0] && wr[0]) || (rd[1] && wr[1])) m_err_rw = 1;
      if (pop) void'(q.pop_front());
      if (sel >= 0) begin
        if (!sw) begin
          if (exp_rd) q.push_back(sel);
          last_m = sel; lock_m = -1; acc[sel] = 1;
        end else lock_m = sel;
      end else lock_m = -1;
      for (int i = 0; i < 2; i++) hold[i] = (rd[i] || wr[i]) && !acc[i];
    end
    clear_inputs();
  endtask

  task automatic test_errors();
    apply_reset();
    s_readdatavalid = 1;
    settle();
    tests_run++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      tests_failed++; $display("FAIL unexp_no_rdv: got %b%b required 00", m0_readdatavalid, m1_readdatavalid);
    end
    tick();
    s_readdatavalid = 0;
    settle();
    tests_run++;
    if (err_unexp_rdv !== 1'b1 || pend_count !== '0) begin
      tests_failed++; $display("FAIL unexp_flag: err=%b pend=%0d required 1 0", err_unexp_rdv, pend_count);
    end
    m0_read = 1; m0_write = 1; m0_address = 32'h77;
    settle();
    tests_run++;
    if (s_write !== 1'b1 || s_read !== 1'b0) begin
      tests_failed++; $display("FAIL rw_as_write: wr=%b rd=%b required 1 0", s_write, s_read);
    end
    tick();
    m0_write = 0;
    settle();
    tests_run++;
    if (err_rw_both !== 1'b1 || pend_count !== '0) begin
      tests_failed++; $display("FAIL rw_flag: err=%b pend=%0d required 1 0", err_rw_both, pend_count);
    end
    repeat (3) tick();
    m1_write = 1;
    settle();
    tests_run++;
    if (pend_count !== 4'd3) begin
      tests_failed++; $display("FAIL pre_reset_pend: got %0d required 3", pend_count);
    end
    reset_reset_n = 0;
    #1;
    tests_run++;
    if (pend_count !== '0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0 ||
        s_write !== 1'b0 || err_unexp_rdv !== 1'b0 || err_rw_both !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: pend=%0d w=%b%b cmd=%b%b err=%b%b required 0 11 00 00", pend_count,
               m0_waitrequest, m1_waitrequest, s_read, s_write, err_unexp_rdv, err_rw_both);
    end
    clear_inputs();
    tick();
    reset_reset_n = 1;
    tick();
    s_readdatavalid = 1;
    settle();
    tests_run++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      tests_failed++; $display("FAIL stale_rdv: got %b%b required 00", m0_readdatavalid, m1_readdatavalid);
    end
    tick();
    s_readdatavalid = 0;
    settle();
    tests_run++;
    if (err_unexp_rdv !== 1'b1 || pend_count !== '0) begin
      tests_failed++; $display("FAIL stale_flag: err=%b pend=%0d required 1 0", err_unexp_rdv, pend_count);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset_reset_n = 0;
    #1;
    test_reset();
    test_single_write();
    test_contention();
    test_lock();
    test_read_routing();
    test_full_stall();
    test_random();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
